convo_core_kxk: RTL

Parametrised successor to the fixed 2x2 FP32 convolution core. Multiplies a KSIZE x KSIZE window by a loadable kernel and reduces the products through a registered FP_Adder tree. It accumulates partial sums across NUM_CH input channels, then applies bias and optional ReLU. Sits between the line-buffer/window generator and the feature-map writeback. Fully pipelined: one window per cycle, valid carried per stage.

---
 rtl/convo_core_kxk_if.sv | 29 ++
 rtl/convo_core_kxk.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/convo_core_kxk_if.sv
// Bus bundle for convo_core_kxk: window stream, coefficient port, ReLU control and result.
// The master drives windows and coefficients; the slave (the core) returns results.
interface convo_core_kxk_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KSIZE      = 3
);
    localparam int KK = KSIZE * KSIZE;
    localparam int AW = $clog2(KK + 1);

    logic                       Clear_In;
    logic                       Valid_In;
    logic [KK*DATA_WIDTH-1:0]   Data_In;
    logic                       Kern_We;
    logic [AW-1:0]              Kern_Addr;
    logic [DATA_WIDTH-1:0]      Kern_Data;
    logic                       Relu_En;
    logic [DATA_WIDTH-1:0]      Data_Out;
    logic                       Valid_Out;

    modport master (
        output Clear_In, Valid_In, Data_In, Kern_We, Kern_Addr, Kern_Data, Relu_En,
        input  Data_Out, Valid_Out
    );

    modport slave (
        input  Clear_In, Valid_In, Data_In, Kern_We, Kern_Addr, Kern_Data, Relu_En,
        output Data_Out, Valid_Out
    );
endinterface

// File: rtl/convo_core_kxk.sv
// KSIZE x KSIZE FP32 convolution core: tap multiply, registered pairwise adder tree,
// channel accumulation, bias add and optional ReLU. One window per cycle, latency L+3.
// Arithmetic is IEEE-754 single, round-nearest-even; subnormal inputs are read as zero
// and subnormal results flush to signed zero. DATA_WIDTH must be 32.
module convo_core_kxk #(
    parameter int DATA_WIDTH = 32,
    parameter int KSIZE      = 3,
    parameter int NUM_CH     = 1
) (
    input  logic            clk,
    input  logic            rst,
    convo_core_kxk_if.slave bus
);
    localparam int KK = KSIZE * KSIZE;
    localparam int L  = $clog2(KK);
    localparam int AW = $clog2(KK + 1);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Round a 24-bit significand (hidden bit at [23]) with guard/sticky, then pack.
    function automatic logic [31:0] fp_round(input logic s, input logic [9:0] e_in,
                                             input logic [23:0] m, input logic g,
                                             input logic st);
        logic [24:0] r;
        logic [9:0]  e;
        logic [31:0] res;
        e = e_in;
        r = {1'b0, m} + 25'(g & (st | m[0]));
        if (r[24]) begin
            r = {1'b0, r[24:1]};
            e = e + 10'd1;
        end
        if (e[9] || (e == 10'd0))
            res = {s, 31'h0};
        else if (e >= 10'd255)
            res = {s, 8'hFF, 23'h0};
        else
            res = {s, e[7:0], r[22:0]};
        return res;
    endfunction

    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, g, st;
        logic [47:0] p;
        logic [9:0]  e;
        logic [23:0] m;
        logic [31:0] res;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
        if (p[47]) begin
            m  = p[47:24];
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'd1;
        end else begin
            m  = p[46:23];
            g  = p[22];
            st = |p[21:0];
        end
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            res = QNAN;
        else if (a_inf || b_inf)
            res = {s, 8'hFF, 23'h0};
        else if (a_zero || b_zero)
            res = {s, 31'h0};
        else
            res = fp_round(s, e, m, g, st);
        return res;
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sticky;
        logic [31:0] x, y, res;
        logic [7:0]  d;
        logic [26:0] mx, my, my_sh;
        logic [27:0] s;
        logic [4:0]  lz;
        logic [9:0]  e;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        // x carries the larger magnitude so the aligned difference is never negative
        if (a[30:0] >= b[30:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        // bits shifted past the round position collapse into a sticky LSB
        if (d > 8'd26) begin
            my_sh = 27'd1;
        end else begin
            sticky = |(my << (8'd27 - d));
            my_sh  = my >> d;
            my_sh[0] = my_sh[0] | sticky;
        end
        if (x[31] == y[31])
            s = {1'b0, mx} + {1'b0, my_sh};
        else
            s = {1'b0, mx} - {1'b0, my_sh};
        e = 10'(x[30:23]);
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            lz = 5'd0;
            for (int i = 0; i < 27; i++)
                if (s[i]) lz = 5'(26 - i);
            s = s << lz;
            e = e - 10'(lz);
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31])))
            res = QNAN;
        else if (a_inf)
            res = a;
        else if (b_inf)
            res = b;
        else if (a_zero && b_zero)
            res = {a[31] & b[31], 31'h0};
        else if (a_zero)
            res = b;
        else if (b_zero)
            res = a;
        else if (s == 28'd0)
            res = 32'h0;
        else
            res = fp_round(x[31], e, s[26:3], s[2], |s[1:0]);
        return res;
    endfunction

    // Coefficients 0..KK-1 are taps, entry KK is the bias.
    logic [DATA_WIDTH-1:0] coef_q [KK+1];
    logic [DATA_WIDTH-1:0] coef_d [KK+1];

    // Coefficient write decode; addresses above KK match no entry and are dropped.
    always_comb begin
        coef_d = coef_q;
        for (int i = 0; i <= KK; i++)
            if (bus.Kern_We && (bus.Kern_Addr == AW'(i)))
                coef_d[i] = bus.Kern_Data;
    end

    // Coefficient storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i <= KK; i++) coef_q[i] <= '0;
        end else begin
            coef_q <= coef_d;
        end
    end

    // Level 0 holds the products; level gl holds ceil(KK/2^gl) partial sums.
    // Every level is sized KK+1 with unused entries held at +0.0, so an odd
    // element reads a zero partner from the pad slot.
    for (genvar gl = 0; gl <= L; gl++) begin : g_lvl
        localparam int N = (KK + (1 << gl) - 1) >> gl;
        logic [DATA_WIDTH-1:0] sum_q [KK+1];
        logic [DATA_WIDTH-1:0] sum_d [KK+1];
        logic                  vld_q;
        logic                  vld_d;

        if (gl == 0) begin : g_mul
            // Multiply stage: capture KK products when a window is accepted.
            always_comb begin
                for (int i = 0; i <= KK; i++) sum_d[i] = '0;
                for (int i = 0; i < N; i++)
                    sum_d[i] = (bus.Valid_In && !bus.Clear_In)
                             ? fp_mul(bus.Data_In[i*DATA_WIDTH +: DATA_WIDTH], coef_q[i])
                             : sum_q[i];
                vld_d = bus.Valid_In && !bus.Clear_In;
            end
        end else begin : g_add
            // Adder level: pairwise sums of the previous level when it is valid.
            always_comb begin
                for (int i = 0; i <= KK; i++) sum_d[i] = '0;
                for (int i = 0; i < N; i++)
                    sum_d[i] = g_lvl[gl-1].vld_q
                             ? fp_add(g_lvl[gl-1].sum_q[2*i], g_lvl[gl-1].sum_q[2*i+1])
                             : sum_q[i];
                vld_d = g_lvl[gl-1].vld_q && !bus.Clear_In;
            end
        end

        // Level registers.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                vld_q <= 1'b0;
                for (int i = 0; i <= KK; i++) sum_q[i] <= '0;
            end else begin
                vld_q <= vld_d;
                sum_q <= sum_d;
            end
        end
    end

    logic [DATA_WIDTH-1:0] tree_sum;
    logic                  tree_vld;
    assign tree_sum = g_lvl[L].sum_q[0];
    assign tree_vld = g_lvl[L].vld_q;

    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]         ch_cnt_q, ch_cnt_d;
    logic                  a_vld_q, a_vld_d;

    // Channel accumulation: restart on the first channel, flag the last one.
    always_comb begin
        acc_d    = acc_q;
        ch_cnt_d = ch_cnt_q;
        a_vld_d  = 1'b0;
        if (bus.Clear_In) begin
            ch_cnt_d = '0;
        end else if (tree_vld) begin
            acc_d = (ch_cnt_q == '0) ? tree_sum : fp_add(acc_q, tree_sum);
            if (ch_cnt_q == CW'(NUM_CH - 1)) begin
                ch_cnt_d = '0;
                a_vld_d  = 1'b1;
            end else begin
                ch_cnt_d = ch_cnt_q + CW'(1);
            end
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q    <= '0;
            ch_cnt_q <= '0;
            a_vld_q  <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ch_cnt_q <= ch_cnt_d;
            a_vld_q  <= a_vld_d;
        end
    end

    logic [DATA_WIDTH-1:0] out_sum;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  o_vld_q, o_vld_d;

    // Output stage: bias add and ReLU; Data_Out holds between completions.
    always_comb begin
        out_sum    = fp_add(acc_q, coef_q[KK]);
        data_out_d = data_out_q;
        o_vld_d    = 1'b0;
        if (a_vld_q && !bus.Clear_In) begin
            data_out_d = (bus.Relu_En && out_sum[31]) ? '0 : out_sum;
            o_vld_d    = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= '0;
            o_vld_q    <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            o_vld_q    <= o_vld_d;
        end
    end

    assign bus.Data_Out  = data_out_q;
    assign bus.Valid_Out = o_vld_q;
endmodule
